// File: rtl/bw_mpu_bus_ctrl.sv
// BlackWidow core to MPU bus controller: decodes PIT/PIC/external, steers 32-bit lanes, times out.
// Define BWMPU_LANE_SPLIT_EN to split multi-lane peripheral accesses into sequential 32-bit beats.
module bw_mpu_bus_ctrl #(
   parameter logic [19:0] PIT_BASE  = 20'hFF960,
   parameter logic [19:0] PIC_BASE  = 20'hFF9C0,
   parameter int unsigned TO_CYCLES = 255
) (
   input  logic         clk_i,
   input  logic         rst_i,
   input  logic         cpu_cyc_i,
   input  logic         cpu_stb_i,
   input  logic         cpu_we_i,
   input  logic [15:0]  cpu_sel_i,
   input  logic [31:0]  cpu_adr_i,
   input  logic [127:0] cpu_dat_i,
   output logic         cpu_ack_o,
   output logic         cpu_err_o,
   output logic [127:0] cpu_dat_o,
   output logic         bus_we_o,
   output logic [31:0]  bus_adr_o,
   output logic         per_cyc_o,
   output logic         per_stb_o,
   output logic [3:0]   per_sel_o,
   output logic [31:0]  per_dat_o,
   input  logic         per_ack_i,
   input  logic [31:0]  per_dat_i,
   output logic         pit_cs_o,
   output logic         pic_cs_o,
   output logic         ext_cyc_o,
   output logic         ext_stb_o,
   output logic [15:0]  ext_sel_o,
   output logic [127:0] ext_dat_o,
   input  logic         ext_ack_i,
   input  logic         ext_err_i,
   input  logic [127:0] ext_dat_i
);

   typedef enum logic [2:0] {StIdle, StPer, StExt, StResp, StRel} state_e;

   localparam logic [7:0] ToLoad = 8'(TO_CYCLES);
`ifdef BWMPU_LANE_SPLIT_EN
   localparam bit LaneSplit = 1'b1;
`else
   localparam bit LaneSplit = 1'b0;
`endif

   state_e       state_q, state_d;
   logic [7:0]   timer_q, timer_d;
   logic         ack_q, ack_d, err_q, err_d;
   logic [127:0] rd_q, rd_d;
   logic         we_q, we_d;
   logic [31:0]  adr_q, adr_d;
   logic         per_cyc_q, per_cyc_d, per_stb_q, per_stb_d;
   logic [3:0]   per_sel_q, per_sel_d;
   logic [31:0]  per_dat_q, per_dat_d;
   logic         pit_cs_q, pit_cs_d, pic_cs_q, pic_cs_d;
   logic         ext_cyc_q, ext_cyc_d, ext_stb_q, ext_stb_d;
   logic [15:0]  ext_sel_q, ext_sel_d;
   logic [127:0] ext_dat_q, ext_dat_d;

   logic [3:0]   req_hits;
   logic [1:0]   req_lane;
   logic         req_multi, pit_hit, pic_hit, end_tgt;

`ifdef BWMPU_LANE_SPLIT_EN
   logic [15:0]  sel_q, sel_d;
   logic [127:0] wr_q, wr_d;
   logic [127:0] merge_q, merge_d;
   logic         first_q, first_d;
   logic [1:0]   cur_lane, rest_lane;
   logic [15:0]  rest;
   logic [127:0] merged;
`endif

   // Bit i set when byte-select group i (one 32-bit lane) is non-zero.
   function automatic logic [3:0] lane_hits(input logic [15:0] s);
      lane_hits = 4'd0;
      for (int i = 0; i < 4; i++) lane_hits[i] = |s[4*i +: 4];
   endfunction

   function automatic logic [1:0] low_lane(input logic [3:0] h);
      low_lane = 2'd0;
      for (int i = 3; i >= 0; i--) if (h[i]) low_lane = 2'(i);
   endfunction

   always_comb begin
      state_d   = state_q;
      timer_d   = timer_q;
      ack_d     = 1'b0;
      err_d     = 1'b0;
      rd_d      = rd_q;
      we_d      = we_q;
      adr_d     = adr_q;
      per_cyc_d = per_cyc_q;
      per_stb_d = per_stb_q;
      per_sel_d = per_sel_q;
      per_dat_d = per_dat_q;
      pit_cs_d  = pit_cs_q;
      pic_cs_d  = pic_cs_q;
      ext_cyc_d = ext_cyc_q;
      ext_stb_d = ext_stb_q;
      ext_sel_d = ext_sel_q;
      ext_dat_d = ext_dat_q;
      end_tgt   = 1'b0;
      req_hits  = lane_hits(cpu_sel_i);
      req_lane  = low_lane(req_hits);
      req_multi = (req_hits & (req_hits - 4'd1)) != 4'd0;
      pit_hit   = cpu_adr_i[31:12] == PIT_BASE;
      pic_hit   = cpu_adr_i[31:12] == PIC_BASE;
`ifdef BWMPU_LANE_SPLIT_EN
      sel_d     = sel_q;
      wr_d      = wr_q;
      merge_d   = merge_q;
      first_d   = first_q;
      cur_lane  = adr_q[3:2];
      rest      = sel_q;
      rest[4*cur_lane +: 4] = 4'h0;
      rest_lane = low_lane(lane_hits(rest));
      merged    = first_q ? {4{per_dat_i}} : merge_q;
      merged[32*cur_lane +: 32] = per_dat_i;
`endif

      unique case (state_q)
         StIdle: begin
            if (cpu_cyc_i && cpu_stb_i) begin
               we_d    = cpu_we_i;
               timer_d = ToLoad;
`ifdef BWMPU_LANE_SPLIT_EN
               sel_d   = cpu_sel_i;
               wr_d    = cpu_dat_i;
               first_d = 1'b1;
`endif
               if (pit_hit || pic_hit) begin
                  if (req_hits == 4'd0 || (req_multi && !LaneSplit)) begin
                     state_d = StResp;
                     err_d   = 1'b1;
                  end else begin
                     state_d   = StPer;
                     per_cyc_d = 1'b1;
                     per_stb_d = 1'b1;
                     pit_cs_d  = pit_hit;
                     pic_cs_d  = !pit_hit;
                     adr_d     = {cpu_adr_i[31:4], req_lane, 2'b00};
                     per_sel_d = cpu_sel_i[4*req_lane +: 4];
                     per_dat_d = cpu_dat_i[32*req_lane +: 32];
                  end
               end else begin
                  state_d   = StExt;
                  ext_cyc_d = 1'b1;
                  ext_stb_d = 1'b1;
                  ext_sel_d = cpu_sel_i;
                  ext_dat_d = cpu_dat_i;
                  adr_d     = cpu_adr_i;
               end
            end
         end
         StPer: begin
            if (!cpu_cyc_i) begin
               state_d = StIdle;
               end_tgt = 1'b1;
            end else if (timer_q == 8'd0) begin
               state_d = StResp;
               err_d   = 1'b1;
               end_tgt = 1'b1;
            end else if (per_ack_i) begin
`ifdef BWMPU_LANE_SPLIT_EN
               if (rest != 16'd0) begin
                  // Next beat keeps cyc/stb asserted and moves to the next selected lane.
                  sel_d     = rest;
                  merge_d   = merged;
                  first_d   = 1'b0;
                  timer_d   = ToLoad;
                  adr_d     = {adr_q[31:4], rest_lane, 2'b00};
                  per_sel_d = rest[4*rest_lane +: 4];
                  per_dat_d = wr_q[32*rest_lane +: 32];
               end else begin
                  if (!we_q) rd_d = merged;
                  state_d = StResp;
                  ack_d   = 1'b1;
                  end_tgt = 1'b1;
               end
`else
               if (!we_q) rd_d = {4{per_dat_i}};
               state_d = StResp;
               ack_d   = 1'b1;
               end_tgt = 1'b1;
`endif
            end else begin
               timer_d = timer_q - 8'd1;
            end
         end
         StExt: begin
            if (!cpu_cyc_i) begin
               state_d = StIdle;
               end_tgt = 1'b1;
            end else if (ext_err_i || timer_q == 8'd0) begin
               state_d = StResp;
               err_d   = 1'b1;
               end_tgt = 1'b1;
            end else if (ext_ack_i) begin
               if (!we_q) rd_d = ext_dat_i;
               state_d = StResp;
               ack_d   = 1'b1;
               end_tgt = 1'b1;
            end else begin
               timer_d = timer_q - 8'd1;
            end
         end
         StResp: state_d = StRel;
         StRel: begin
            if (!cpu_stb_i) state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase

      if (end_tgt) begin
         per_cyc_d = 1'b0;
         per_stb_d = 1'b0;
         pit_cs_d  = 1'b0;
         pic_cs_d  = 1'b0;
         ext_cyc_d = 1'b0;
         ext_stb_d = 1'b0;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q   <= StIdle;
         timer_q   <= 8'd0;
         ack_q     <= 1'b0;
         err_q     <= 1'b0;
         rd_q      <= '0;
         we_q      <= 1'b0;
         adr_q     <= '0;
         per_cyc_q <= 1'b0;
         per_stb_q <= 1'b0;
         per_sel_q <= '0;
         per_dat_q <= '0;
         pit_cs_q  <= 1'b0;
         pic_cs_q  <= 1'b0;
         ext_cyc_q <= 1'b0;
         ext_stb_q <= 1'b0;
         ext_sel_q <= '0;
         ext_dat_q <= '0;
`ifdef BWMPU_LANE_SPLIT_EN
         sel_q     <= '0;
         wr_q      <= '0;
         merge_q   <= '0;
         first_q   <= 1'b0;
`endif
      end else begin
         state_q   <= state_d;
         timer_q   <= timer_d;
         ack_q     <= ack_d;
         err_q     <= err_d;
         rd_q      <= rd_d;
         we_q      <= we_d;
         adr_q     <= adr_d;
         per_cyc_q <= per_cyc_d;
         per_stb_q <= per_stb_d;
         per_sel_q <= per_sel_d;
         per_dat_q <= per_dat_d;
         pit_cs_q  <= pit_cs_d;
         pic_cs_q  <= pic_cs_d;
         ext_cyc_q <= ext_cyc_d;
         ext_stb_q <= ext_stb_d;
         ext_sel_q <= ext_sel_d;
         ext_dat_q <= ext_dat_d;
`ifdef BWMPU_LANE_SPLIT_EN
         sel_q     <= sel_d;
         wr_q      <= wr_d;
         merge_q   <= merge_d;
         first_q   <= first_d;
`endif
      end
   end

   assign cpu_ack_o = ack_q;
   assign cpu_err_o = err_q;
   assign cpu_dat_o = rd_q;
   assign bus_we_o  = we_q;
   assign bus_adr_o = adr_q;
   assign per_cyc_o = per_cyc_q;
   assign per_stb_o = per_stb_q;
   assign per_sel_o = per_sel_q;
   assign per_dat_o = per_dat_q;
   assign pit_cs_o  = pit_cs_q;
   assign pic_cs_o  = pic_cs_q;
   assign ext_cyc_o = ext_cyc_q;
   assign ext_stb_o = ext_stb_q;
   assign ext_sel_o = ext_sel_q;
   assign ext_dat_o = ext_dat_q;

endmodule

// File: tb/tb_bw_mpu_bus_ctrl.sv
// Directed scoreboard bench for bw_mpu_bus_ctrl; the bench acts as CPU, peripheral and external target.
module tb_bw_mpu_bus_ctrl;

   localparam int TO = 255;

   logic         clk = 1'b0;
   logic         rst;
   logic         cpu_cyc, cpu_stb, cpu_we;
   logic [15:0]  cpu_sel;
   logic [31:0]  cpu_adr;
   logic [127:0] cpu_dat;
   logic         cpu_ack, cpu_err;
   logic [127:0] cpu_rdat;
   logic         bus_we;
   logic [31:0]  bus_adr;
   logic         per_cyc, per_stb;
   logic [3:0]   per_sel;
   logic [31:0]  per_wdat;
   logic         per_ack;
   logic [31:0]  per_rdat;
   logic         pit_cs, pic_cs;
   logic         ext_cyc, ext_stb;
   logic [15:0]  ext_sel;
   logic [127:0] ext_wdat;
   logic         ext_ack, ext_err;
   logic [127:0] ext_rdat;
   logic         any_out;

   always #5 clk = ~clk;

   bw_mpu_bus_ctrl #(
      .PIT_BASE  (20'hFF960),
      .PIC_BASE  (20'hFF9C0),
      .TO_CYCLES (TO)
   ) dut (
      .clk_i     (clk),
      .rst_i     (rst),
      .cpu_cyc_i (cpu_cyc),
      .cpu_stb_i (cpu_stb),
      .cpu_we_i  (cpu_we),
      .cpu_sel_i (cpu_sel),
      .cpu_adr_i (cpu_adr),
      .cpu_dat_i (cpu_dat),
      .cpu_ack_o (cpu_ack),
      .cpu_err_o (cpu_err),
      .cpu_dat_o (cpu_rdat),
      .bus_we_o  (bus_we),
      .bus_adr_o (bus_adr),
      .per_cyc_o (per_cyc),
      .per_stb_o (per_stb),
      .per_sel_o (per_sel),
      .per_dat_o (per_wdat),
      .per_ack_i (per_ack),
      .per_dat_i (per_rdat),
      .pit_cs_o  (pit_cs),
      .pic_cs_o  (pic_cs),
      .ext_cyc_o (ext_cyc),
      .ext_stb_o (ext_stb),
      .ext_sel_o (ext_sel),
      .ext_dat_o (ext_wdat),
      .ext_ack_i (ext_ack),
      .ext_err_i (ext_err),
      .ext_dat_i (ext_rdat)
   );

   assign any_out = |{cpu_ack, cpu_err, cpu_rdat, bus_we, bus_adr, per_cyc, per_stb, per_sel,
                      per_wdat, pit_cs, pic_cs, ext_cyc, ext_stb, ext_sel, ext_wdat};

   typedef struct packed {
      logic         ack;
      logic         err;
      logic [127:0] dat;
   } resp_t;

   resp_t        exp_q[$];
   int           checks = 0;
   int           failures = 0;
   int           resp_lat, n_ack, n_err, per_seen, ext_seen, extra_tgt;
   bit           ext_drop_ok;
   logic         ext_cyc_at_resp;
   logic [31:0]  adr_seen, pdat_seen;
   logic [3:0]   psel_seen;
   logic [1:0]   cs_seen;
   logic [15:0]  esel_seen;
   logic [127:0] edat_seen;
   logic [1:0]   beats[$];

   function automatic resp_t mk(input logic a, input logic e, input logic [127:0] d);
      resp_t r;
      r.ack = a;
      r.err = e;
      r.dat = d;
      return r;
   endfunction

   task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
      checks++;
      assert (got === exp) else begin
         failures++;
         $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic chk_i(input string tag, input int got, input int exp);
      checks++;
      assert (got === exp) else begin
         failures++;
         $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic count_tail();
      step();
      n_ack += int'(cpu_ack);
      n_err += int'(cpu_err);
      if (per_stb || ext_stb) extra_tgt++;
   endtask

   // One CPU transaction; the bench plays the addressed target, acking after ack_after strobe
   // cycles (0 = never). The expected CPU response is queued on issue and checked on arrival.
   task automatic xfer(input string tag, input logic [31:0] adr, input logic [15:0] sel,
                       input logic we, input logic [127:0] wdat, input int ack_after,
                       input bit terr, input bit both, input logic [127:0] rdat,
                       input int hold, input resp_t exp);
      int    tgt_cnt;
      int    beat;
      bit    handshake;
      resp_t got;
      resp_t exp_r;
      tgt_cnt = 0;
      beat = 0;
      got = '0;
      resp_lat = -1;
      n_ack = 0;
      n_err = 0;
      per_seen = 0;
      ext_seen = 0;
      extra_tgt = 0;
      ext_drop_ok = 1'b1;
      ext_cyc_at_resp = 1'bx;
      beats.delete();
      exp_q.push_back(exp);
      cpu_adr = adr;
      cpu_sel = sel;
      cpu_we  = we;
      cpu_dat = wdat;
      cpu_cyc = 1'b1;
      cpu_stb = 1'b1;
      for (int cyc = 1; cyc <= 400 && resp_lat < 0; cyc++) begin
         step();
         handshake = per_ack | ext_ack | ext_err;
         per_ack  = 1'b0;
         per_rdat = '0;
         ext_ack  = 1'b0;
         ext_err  = 1'b0;
         ext_rdat = '0;
         if (cpu_ack || cpu_err) begin
            resp_lat = cyc;
            n_ack += int'(cpu_ack);
            n_err += int'(cpu_err);
            got = mk(cpu_ack, cpu_err, cpu_rdat);
            ext_cyc_at_resp = ext_cyc;
         end
         if (handshake && ext_stb) ext_drop_ok = 1'b0;
         if (per_stb) begin
            per_seen++;
            if (tgt_cnt == 0) beats.push_back(bus_adr[3:2]);
            adr_seen  = bus_adr;
            psel_seen = per_sel;
            pdat_seen = per_wdat;
            cs_seen   = {pit_cs, pic_cs};
         end
         if (ext_stb) begin
            ext_seen++;
            adr_seen  = bus_adr;
            esel_seen = ext_sel;
            edat_seen = ext_wdat;
         end
         if ((per_stb || ext_stb) && ack_after > 0) begin
            tgt_cnt++;
            if (tgt_cnt == ack_after) begin
               tgt_cnt = 0;
               if (per_stb) begin
                  per_ack  = 1'b1;
                  per_rdat = rdat[32*beat +: 32];
                  beat++;
               end else begin
                  ext_ack  = !terr || both;
                  ext_err  = terr;
                  ext_rdat = rdat;
               end
            end
         end
      end
      exp_r = exp_q.pop_front();
      chk_i({tag, "_resp_seen"}, int'(resp_lat >= 0), 1);
      if (resp_lat >= 0) begin
         chk({tag, "_ack"}, 128'(got.ack), 128'(exp_r.ack));
         chk({tag, "_err"}, 128'(got.err), 128'(exp_r.err));
         chk({tag, "_dat"}, got.dat, exp_r.dat);
      end
      for (int i = 0; i < hold; i++) count_tail();
      cpu_stb = 1'b0;
      cpu_cyc = 1'b0;
      count_tail();
      count_tail();
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog expired at %0t", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      logic [127:0] last_rd, w1, w2, r1;
      rst = 1'b1;
      cpu_cyc = 1'b0;
      cpu_stb = 1'b0;
      cpu_we = 1'b0;
      cpu_sel = '0;
      cpu_adr = '0;
      cpu_dat = '0;
      per_ack = 1'b0;
      per_rdat = '0;
      ext_ack = 1'b0;
      ext_err = 1'b0;
      ext_rdat = '0;
      w1 = {$urandom(), $urandom(), $urandom(), $urandom()};
      w2 = {$urandom(), $urandom(), $urandom(), $urandom()};
      r1 = {$urandom(), $urandom(), $urandom(), $urandom()};
      repeat (2) step();
      chk_i("reset_outs", int'(any_out), 0);
      rst = 1'b0;
      step();

      // PIT read on lane 2, registered target ack, CPU holds stb for 4 cycles after ack.
      last_rd = {4{32'h12345678}};
      xfer("pit_rd", 32'hFF960008, 16'h0F00, 1'b0, '0, 2, 1'b0, 1'b0, {96'd0, 32'h12345678},
           4, mk(1'b1, 1'b0, last_rd));
      chk("pit_rd_sel", 128'(psel_seen), 128'(4'hF));
      chk("pit_rd_adr", 128'(adr_seen), 128'(32'hFF960008));
      chk("pit_rd_cs", 128'(cs_seen), 128'(2'b10));
      chk_i("pit_rd_lat", resp_lat, 3);
      chk_i("pit_rd_acks", n_ack, 1);
      chk_i("pit_rd_hold_no_tgt", extra_tgt, 0);

      // External write, ack at the fifth strobe cycle.
      xfer("ext_wr", 32'h00100000, 16'hFFFF, 1'b1, w1, 5, 1'b0, 1'b0, '0, 0,
           mk(1'b1, 1'b0, last_rd));
      chk("ext_wr_dat", edat_seen, w1);
      chk("ext_wr_sel", 128'(esel_seen), 128'(16'hFFFF));
      chk("ext_wr_adr", 128'(adr_seen), 128'(32'h00100000));
      chk_i("ext_wr_lat", resp_lat, 6);
      chk_i("ext_wr_acks", n_ack, 1);
      chk_i("ext_wr_stb_drop", int'(ext_drop_ok), 1);
      chk_i("ext_wr_no_per", per_seen, 0);

      // External read with no answer: timeout error.
      xfer("ext_to", 32'h00200040, 16'h00F0, 1'b0, '0, 0, 1'b0, 1'b0, '0, 0,
           mk(1'b0, 1'b1, last_rd));
      chk_i("ext_to_lat", resp_lat, TO + 2);
      chk_i("ext_to_cyc_low", int'(ext_cyc_at_resp), 0);
      chk_i("ext_to_errs", n_err, 1);
      chk_i("ext_to_acks", n_ack, 0);

      // PIC write spanning lanes 0 and 1.
`ifdef BWMPU_LANE_SPLIT_EN
      xfer("pic_multi", 32'hFF9C0000, 16'h00FF, 1'b1, w1, 1, 1'b0, 1'b0, '0, 0,
           mk(1'b1, 1'b0, last_rd));
      chk_i("pic_multi_beats", beats.size(), 2);
      if (beats.size() == 2) begin
         chk("pic_multi_beat0", 128'(beats[0]), 128'(2'd0));
         chk("pic_multi_beat1", 128'(beats[1]), 128'(2'd1));
      end
      chk_i("pic_multi_acks", n_ack, 1);
`else
      xfer("pic_multi", 32'hFF9C0000, 16'h00FF, 1'b1, w1, 1, 1'b0, 1'b0, '0, 0,
           mk(1'b0, 1'b1, last_rd));
      chk_i("pic_multi_no_stb", per_seen, 0);
      chk_i("pic_multi_lat", resp_lat, 1);
      chk_i("pic_multi_errs", n_err, 1);
`endif

      // Target ack and err together: err only.
      xfer("ext_both", 32'h00300000, 16'h000F, 1'b0, '0, 3, 1'b1, 1'b1, r1, 0,
           mk(1'b0, 1'b1, last_rd));
      chk_i("ext_both_acks", n_ack, 0);
      chk_i("ext_both_errs", n_err, 1);

      // External read data, back-to-back with the next cycle.
      xfer("ext_rd", 32'h00400010, 16'hFFFF, 1'b0, '0, 1, 1'b0, 1'b0, r1, 0,
           mk(1'b1, 1'b0, r1));
      chk_i("ext_rd_lat", resp_lat, 2);
      last_rd = {4{32'hCAFEF00D}};

      // PIC read on lane 3, address low bits rebuilt from the lane.
      xfer("pic_rd", 32'hFF9C0003, 16'hF000, 1'b0, '0, 2, 1'b0, 1'b0, {96'd0, 32'hCAFEF00D},
           0, mk(1'b1, 1'b0, last_rd));
      chk("pic_rd_adr", 128'(adr_seen), 128'(32'hFF9C000C));
      chk("pic_rd_cs", 128'(cs_seen), 128'(2'b01));

      // PIT write on lane 1: lane data and partial byte selects steered.
      xfer("pit_wr", 32'hFF960000, 16'h0030, 1'b1, w2, 1, 1'b0, 1'b0, '0, 0,
           mk(1'b1, 1'b0, last_rd));
      chk("pit_wr_dat", 128'(pdat_seen), 128'(w2[63:32]));
      chk("pit_wr_sel", 128'(psel_seen), 128'(4'h3));
      chk("pit_wr_adr", 128'(adr_seen), 128'(32'hFF960004));

      // No byte selects on a peripheral access.
      xfer("pit_sel0", 32'hFF960000, 16'h0000, 1'b0, '0, 1, 1'b0, 1'b0, '0, 0,
           mk(1'b0, 1'b1, last_rd));
      chk_i("pit_sel0_no_stb", per_seen, 0);

      // CPU abandons an external cycle.
      cpu_adr = 32'h00600000;
      cpu_sel = 16'hFFFF;
      cpu_we  = 1'b0;
      cpu_cyc = 1'b1;
      cpu_stb = 1'b1;
      step();
      step();
      chk_i("abort_pre_cyc", int'(ext_cyc), 1);
      cpu_cyc = 1'b0;
      cpu_stb = 1'b0;
      n_ack = 0;
      n_err = 0;
      extra_tgt = 0;
      count_tail();
      chk_i("abort_cyc_drop", int'(ext_cyc | ext_stb), 0);
      repeat (3) count_tail();
      chk_i("abort_no_resp", n_ack + n_err, 0);

      // Asynchronous reset in the middle of an external cycle.
      cpu_adr = 32'h00500000;
      cpu_cyc = 1'b1;
      cpu_stb = 1'b1;
      repeat (3) step();
      chk_i("rst_pre_ext_cyc", int'(ext_cyc), 1);
      rst = 1'b1;
      #1;
      chk_i("rst_async_outs", int'(any_out), 0);
      cpu_cyc = 1'b0;
      cpu_stb = 1'b0;
      n_ack = 0;
      n_err = 0;
      repeat (2) count_tail();
      rst = 1'b0;
      repeat (2) count_tail();
      chk_i("rst_no_resp", n_ack + n_err, 0);

      // Back-to-back transactions after the abort and the reset (read data was cleared by reset).
      xfer("b2b_a", 32'h00700000, 16'hFFFF, 1'b0, '0, 2, 1'b0, 1'b0, w2, 0,
           mk(1'b1, 1'b0, w2));
      xfer("b2b_b", 32'hFF960004, 16'h00F0, 1'b0, '0, 2, 1'b0, 1'b0, {96'd0, w1[31:0]}, 0,
           mk(1'b1, 1'b0, {4{w1[31:0]}}));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
